// File: rtl/yolo_pkg.sv
// rtl/yolo_pkg.sv - shared constants and state encoding for the YOLO post-processing stages
package yolo_pkg;

  localparam int ACC_W       = 32;
  localparam int LEAKY_SHIFT = 3;

  localparam logic [1:0] ST_ACC_ENC   = 2'd0;
  localparam logic [1:0] ST_BIAS_ENC  = 2'd1;
  localparam logic [1:0] ST_QUANT_ENC = 2'd2;
  localparam logic [1:0] ST_PUSH_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_ACC   = ST_ACC_ENC,
    ST_BIAS  = ST_BIAS_ENC,
    ST_QUANT = ST_QUANT_ENC,
    ST_PUSH  = ST_PUSH_ENC
  } pp_state_e;

endpackage

// File: rtl/pp_sync_fifo.sv
// rtl/pp_sync_fifo.sv - small synchronous FIFO with occupancy count and synchronous clear
module pp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push   = push && (count_q < CNT_W'(DEPTH));
  assign do_pop    = pop && (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Storage is left as-is on clear; only the pointers define occupancy.
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe27_postproc.sv
// rtl/pe27_postproc.sv - accumulate MAC groups, add bias, leaky ReLU, requantize to int8, FIFO out
module pe27_postproc
  import yolo_pkg::*;
#(
  parameter int ACC_W      = yolo_pkg::ACC_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        mac_done,
  input  logic [23:0] mac_out,
  output logic        in_ready,
  input  logic [7:0]  cfg_groups,
  input  logic [15:0] cfg_bias,
  input  logic [4:0]  cfg_shift,
  input  logic        cfg_leaky,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_drop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = 127;
  localparam logic signed [ACC_W-1:0] Q_MIN = -128;

  pp_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] pre_q, pre_d;
  logic [7:0]              grp_cnt_q, grp_cnt_d;
  logic [7:0]              groups_q, groups_d;
  logic [15:0]             bias_q, bias_d;
  logic [4:0]              shift_q, shift_d;
  logic                    leaky_q, leaky_d;
  logic [7:0]              q_q, q_d;
  logic                    err_drop_q, err_drop_d;

  logic                    accept, push, pop;
  logic [CNT_W-1:0]        fifo_count;
  logic [7:0]              eff_groups, last_grp;
  logic signed [ACC_W-1:0] sum_bias, round_bit, shifted;

  assign in_ready = (state_q == ST_ACC) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept   = mac_done && in_ready;
  assign push     = (state_q == ST_PUSH);
  assign pop      = out_valid && out_ready;
  assign err_drop = err_drop_q;

  // The first group of a pixel uses live config; later groups use the shadow copy.
  assign eff_groups = (grp_cnt_q == 8'd0) ? cfg_groups : groups_q;
  assign last_grp   = (eff_groups == 8'd0) ? 8'd0 : eff_groups - 8'd1;

  assign sum_bias  = acc_q + $signed({{(ACC_W-16){bias_q[15]}}, bias_q});
  assign round_bit = (shift_q == 5'd0) ? '0
                   : $signed({{(ACC_W-1){1'b0}}, 1'b1} << (shift_q - 5'd1));
  assign shifted   = (pre_q + round_bit) >>> shift_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pre_d      = pre_q;
    grp_cnt_d  = grp_cnt_q;
    groups_d   = groups_q;
    bias_d     = bias_q;
    shift_d    = shift_q;
    leaky_d    = leaky_q;
    q_d        = q_q;
    err_drop_d = err_drop_q | (mac_done && !in_ready);
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d     = acc_q + $signed({{(ACC_W-24){1'b0}}, mac_out});
          grp_cnt_d = grp_cnt_q + 8'd1;
          if (grp_cnt_q == 8'd0) begin
            groups_d = cfg_groups;
            bias_d   = cfg_bias;
            shift_d  = cfg_shift;
            leaky_d  = cfg_leaky;
          end
          if (grp_cnt_q == last_grp) state_d = ST_BIAS;
        end
      end
      ST_BIAS: begin
        pre_d   = (leaky_q && sum_bias[ACC_W-1]) ? (sum_bias >>> LEAKY_SHIFT) : sum_bias;
        state_d = ST_QUANT;
      end
      ST_QUANT: begin
        if (shifted > Q_MAX)      q_d = 8'h7F;
        else if (shifted < Q_MIN) q_d = 8'h80;
        else                      q_d = shifted[7:0];
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        acc_d     = '0;
        grp_cnt_d = 8'd0;
        state_d   = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
    if (clear) begin
      state_d    = ST_ACC;
      acc_d      = '0;
      grp_cnt_d  = 8'd0;
      err_drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      pre_q      <= '0;
      grp_cnt_q  <= 8'd0;
      groups_q   <= 8'd0;
      bias_q     <= 16'd0;
      shift_q    <= 5'd0;
      leaky_q    <= 1'b0;
      q_q        <= 8'd0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pre_q      <= pre_d;
      grp_cnt_q  <= grp_cnt_d;
      groups_q   <= groups_d;
      bias_q     <= bias_d;
      shift_q    <= shift_d;
      leaky_q    <= leaky_d;
      q_q        <= q_d;
      err_drop_q <= err_drop_d;
    end
  end

  pp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (q_q),
    .pop       (pop),
    .head_data (out_data),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

endmodule
